riscv_data_memory: RTL and testbench

// - Byte-addressed, word-organised RAM: the RISC-V core's data memory. Serves loads and stores of byte, halfword and word.
// - A side flash port preloads whole words (program/data image) before or during reset.
// - Sits between the load/store unit (addr, wren, funct3, wr_data) and the writeback path (rd_data).

---
 rtl/riscv_data_memory.sv | 100 ++++++++++
 tb/tb_riscv_data_memory.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/riscv_data_memory.sv
// riscv_data_memory: byte-addressed, word-organised data RAM for the RISC-V core.
// Little-endian storage with byte/halfword/word stores, sign/zero-extending
// registered loads (read-first), and a full-word flash preload port that keeps
// working while rst is high.
module riscv_data_memory #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] addr,
   input  logic             wren,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [2:0]       funct3,
   output logic [WIDTH-1:0] rd_data,
   input  logic             flash_en,
   input  logic [10:0]      flash_addr,
   input  logic [WIDTH-1:0] flash_data
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] F3_BYTE   = 3'b000;
   localparam logic [2:0] F3_HALF   = 3'b001;
   localparam logic [2:0] F3_WORD   = 3'b010;
   localparam logic [2:0] F3_BYTE_U = 3'b100;
   localparam logic [2:0] F3_HALF_U = 3'b101;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    word_idx;
   logic [AW-1:0]    flash_idx;
   logic [1:0]       lane;
   logic [3:0]       byte_en;
   logic [WIDTH-1:0] st_data;

   // Address bits above the 2 KiB window and the flash byte offset are don't-care.
   logic unused_bits;
   assign unused_bits = ^{addr[WIDTH-1:AW+2], flash_addr[1:0]};

   assign word_idx  = addr[AW+1:2];
   assign flash_idx = flash_addr[AW+1:2];
   assign lane      = addr[1:0];

   // Select the addressed byte/halfword and extend it to a full load result.
   function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] word,
                                                 input logic [1:0]       ln,
                                                 input logic [2:0]       f3);
      logic        [7:0]       b;
      logic        [15:0]      h;
      logic signed [WIDTH-1:0] r;
      b = word[{ln, 3'b000} +: 8];
      h = ln[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_BYTE:   r = WIDTH'(signed'(b));
         F3_HALF:   r = WIDTH'(signed'(h));
         F3_WORD:   r = signed'(word);
         F3_BYTE_U: r = signed'({{(WIDTH-8){1'b0}}, b});
         F3_HALF_U: r = signed'({{(WIDTH-16){1'b0}}, h});
         default:   r = '0;
      endcase
      return r;
   endfunction

   // Store byte enables and lane-replicated store data.
   always_comb begin
      byte_en = 4'b0000;
      st_data = wr_data;
      case (funct3)
         F3_WORD: byte_en = 4'b1111;
         F3_HALF: begin
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wr_data[15:0]}};
         end
         F3_BYTE: begin
            byte_en = 4'b0001 << lane;
            st_data = {4{wr_data[7:0]}};
         end
         default: byte_en = 4'b0000;
      endcase
   end

   // Array writes: flash wins over stores and ignores rst; contents are never reset.
   always_ff @(posedge clk) begin
      if (flash_en) begin
         mem[flash_idx] <= flash_data;
      end else if (!rst && wren) begin
         for (int k = 0; k < 4; k++) begin
            if (byte_en[k]) mem[word_idx][8*k +: 8] <= st_data[8*k +: 8];
         end
      end
   end

   // Registered load path; sampling the array here gives read-first behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= load_ext(mem[word_idx], lane, funct3);
   end

endmodule

// File: tb/tb_riscv_data_memory.sv
// tb_riscv_data_memory: scoreboard bench for riscv_data_memory.
module tb_riscv_data_memory;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        wren;
   logic [31:0] wr_data;
   logic [2:0]  funct3;
   logic [31:0] rd_data;
   logic        flash_en;
   logic [10:0] flash_addr;
   logic [31:0] flash_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb_q[$];

   localparam logic [2:0] BYTE = 3'b000, HALF = 3'b001, WORD = 3'b010;
   localparam logic [2:0] BYTE_U = 3'b100, HALF_U = 3'b101;

   riscv_data_memory #(.WIDTH(32), .DEPTH(512)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wren(wren), .wr_data(wr_data),
      .funct3(funct3), .rd_data(rd_data), .flash_en(flash_en),
      .flash_addr(flash_addr), .flash_data(flash_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle of stimulus; when chk is set the expected rd_data is
   // queued at drive time and compared just after the capturing edge.
   task automatic cyc(input logic [31:0] a, input logic [2:0] f3, input logic w,
                      input logic [31:0] wd, input logic fe, input logic [10:0] fa,
                      input logic [31:0] fd, input bit chk, input logic [31:0] exp,
                      input string nm);
      sb_t e;
      @(negedge clk);
      addr = a; funct3 = f3; wren = w; wr_data = wd;
      flash_en = fe; flash_addr = fa; flash_data = fd;
      if (chk) begin
         e.exp = exp; e.name = nm;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      flash_en = 1'b0; wren = 1'b0;
      if (chk) begin
         e = sb_q.pop_front();
         checks++;
         if (rd_data !== e.exp) begin
            errors++;
            $display("FAIL %s: rd_data=%h expected=%h", e.name, rd_data, e.exp);
         end
      end
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] exp, input string nm);
      cyc(a, f3, 1'b0, 32'h0, 1'b0, 11'h0, 32'h0, 1'b1, exp, nm);
   endtask

   task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
      cyc(a, f3, 1'b1, wd, 1'b0, 11'h0, 32'h0, 1'b0, 32'h0, "");
   endtask

   task automatic fl(input logic [10:0] fa, input logic [31:0] fd);
      cyc(32'h0, WORD, 1'b0, 32'h0, 1'b1, fa, fd, 1'b0, 32'h0, "");
   endtask

   task automatic test_reset;
      // Flash preload during reset; rd_data must stay 0 every cycle.
      cyc(32'h0, WORD, 1'b0, 32'h0, 1'b1, 11'd0,  32'd12345,    1'b1, 32'h0, "rst_flash0");
      cyc(32'h0, WORD, 1'b0, 32'h0, 1'b1, 11'd4,  32'd678910,   1'b1, 32'h0, "rst_flash4");
      cyc(32'h0, WORD, 1'b0, 32'h0, 1'b1, 11'd12, 32'h000000EF, 1'b1, 32'h0, "rst_flash12");
      // A store attempted during reset must be dropped.
      cyc(32'd12, WORD, 1'b1, 32'hDEADBEEF, 1'b0, 11'd0, 32'h0, 1'b1, 32'h0, "rst_store");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_flash_read;
      ld(32'd0,  WORD, 32'd12345,    "flash_rd0");
      ld(32'd4,  WORD, 32'd678910,   "flash_rd4");
      ld(32'd12, WORD, 32'h000000EF, "flash_rd12_no_rst_store");
      ld(32'd13, WORD, 32'h000000EF, "misaligned_word");
      ld(32'd2052, WORD, 32'd678910, "alias_2k");
      ld(32'd4, 3'b011, 32'h0,       "bad_funct3_load");
   endtask

   task automatic test_async_reset;
      ld(32'd0, WORD, 32'd12345, "pre_async_rst");
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
         errors++;
         $display("FAIL async_rst: rd_data=%h expected=%h", rd_data, 32'h0);
      end
      cyc(32'd0, WORD, 1'b0, 32'h0, 1'b0, 11'h0, 32'h0, 1'b1, 32'h0, "rst_hold");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word_store;
      repeat (3) st(32'd8, WORD, 32'd101010);
      ld(32'd8, WORD, 32'h00018A92, "word_store");
   endtask

   task automatic test_subword;
      fl(11'd0, 32'h80FF7F01);
      ld(32'd1, BYTE,   32'h0000007F, "lb_1");
      ld(32'd3, BYTE,   32'hFFFFFF80, "lb_3");
      ld(32'd3, BYTE_U, 32'h00000080, "lbu_3");
      ld(32'd2, HALF,   32'hFFFF80FF, "lh_2");
      ld(32'd2, HALF_U, 32'h000080FF, "lhu_2");
      st(32'd2, BYTE, 32'hFFFFFF12);
      ld(32'd0, WORD,   32'h80127F01, "sb_2");
      st(32'd7, HALF, 32'h1234BEEF);
      ld(32'd4, WORD,   32'hBEEF5BFE, "sh_6");
      ld(32'd7, BYTE,   32'hFFFFFFBE, "lb_7");
      ld(32'd4, HALF_U, 32'h00005BFE, "lhu_4");
      st(32'd4, BYTE_U, 32'h00000000);
      ld(32'd4, WORD,   32'hBEEF5BFE, "store_bad_funct3");
   endtask

   task automatic test_priority;
      cyc(32'd8, WORD, 1'b1, 32'h11111111, 1'b1, 11'd8, 32'hAAAA5555, 1'b0, 32'h0, "");
      ld(32'd8, WORD, 32'hAAAA5555, "flash_priority");
   endtask

   task automatic test_read_first;
      fl(11'd16, 32'h0);
      cyc(32'd16, WORD, 1'b1, 32'hCAFEF00D, 1'b0, 11'h0, 32'h0, 1'b1, 32'h0, "read_first_old");
      ld(32'd16, WORD, 32'hCAFEF00D, "read_first_new");
      // Same behaviour for a flash write hitting the word being loaded.
      cyc(32'd16, WORD, 1'b0, 32'h0, 1'b1, 11'd16, 32'h5A5A0F0F, 1'b1, 32'hCAFEF00D, "flash_read_first_old");
      ld(32'd16, WORD, 32'h5A5A0F0F, "flash_read_first_new");
   endtask

   initial begin
      rst = 1'b1; addr = '0; wren = 1'b0; wr_data = '0; funct3 = WORD;
      flash_en = 1'b0; flash_addr = '0; flash_data = '0;
      #1;
      checks++;
      if (rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_value: rd_data=%h expected=%h", rd_data, 32'h0);
      end
      test_reset();
      test_flash_read();
      test_async_reset();
      test_word_store();
      test_subword();
      test_priority();
      test_read_first();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
